// File: rtl/fft_pkg.sv
// fft_pkg: shared state type and addressing helpers for the radix-2 FFT
// controller (bit reversal, butterfly pair addresses, twiddle index, {re,im} swap).
`timescale 1ns/1ps
package fft_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_ISSUE  = 2'd1,
        S_DRAIN  = 2'd2,
        S_UNLOAD = 2'd3
    } fft_state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] v,
                                           input int unsigned bits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++)
            if (i < bits)
                r = r | (((v >> i) & 32'd1) << (bits - 1 - i));
        return r;
    endfunction

    function automatic logic [31:0] low_mask(input int unsigned s);
        return (32'd1 << s) - 32'd1;
    endfunction

    // Element a of pair j in stage s: insert a zero at bit position s.
    function automatic logic [31:0] pair_a(input logic [31:0] j,
                                           input int unsigned s);
        return ((j >> s) << (s + 1)) | (j & low_mask(s));
    endfunction

    function automatic logic [31:0] pair_b(input logic [31:0] j,
                                           input int unsigned s);
        return pair_a(j, s) + (32'd1 << s);
    endfunction

    function automatic logic [31:0] tw_index(input logic [31:0] j,
                                             input int unsigned s,
                                             input int unsigned log2n);
        return (j & low_mask(s)) << (log2n - 1 - s);
    endfunction

    // Butterfly results come back {re,im}; the store holds {im,re}.
    function automatic logic [63:0] swap_ri(input logic [63:0] v,
                                            input int unsigned dw);
        logic [63:0] m;
        m = (64'd1 << dw) - 64'd1;
        return ((v >> dw) & m) | ((v & m) << dw);
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: stage/pair counters and per-cycle pair addresses a/b plus twiddle index.
// Ports: clk, rst_n, clr/step_j/step_s controls; s, a, b, tw_idx, last_pair, last_stage.
`timescale 1ns/1ps
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             step_j,
    input  logic             step_s,
    output logic [SW-1:0]    s,
    output logic [LOG2N-1:0] a,
    output logic [LOG2N-1:0] b,
    output logic [LOG2N-2:0] tw_idx,
    output logic             last_pair,
    output logic             last_stage
);

    localparam int JW = LOG2N - 1;

    logic [JW-1:0] j;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= '0;
            j <= '0;
        end else if (clr) begin
            s <= '0;
            j <= '0;
        end else if (step_s) begin
            s <= s + 1'b1;
            j <= '0;
        end else if (step_j) begin
            j <= j + 1'b1;
        end
    end

    always_comb begin
        a          = LOG2N'(pair_a(32'(j), 32'(s)));
        b          = LOG2N'(pair_b(32'(j), 32'(s)));
        tw_idx     = JW'(tw_index(32'(j), 32'(s), LOG2N));
        last_pair  = &j;
        last_stage = (s == SW'(LOG2N - 1));
    end

endmodule

// File: rtl/fft_r2_stage_ctrl.sv
// fft_r2_stage_ctrl: in-place radix-2 FFT frame controller feeding one butterfly.
// Ports: in_* load stream, bf_* butterfly port, tw_* LUT, out_* spectrum, busy/frame_done.
`timescale 1ns/1ps
module fft_r2_stage_ctrl
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2N      = 3,
    parameter int BF_LATENCY = 4,
    parameter int A_DELAY    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    output logic [2*DATA_WIDTH-1:0] bf_in_a,
    output logic [2*DATA_WIDTH-1:0] bf_in_b,
    output logic [2*DATA_WIDTH-1:0] bf_w,
    output logic [LOG2N-1:0]        bf_m_in,
    input  logic [2*DATA_WIDTH-1:0] bf_out_a,
    input  logic [2*DATA_WIDTH-1:0] bf_out_b,
    input  logic [LOG2N-1:0]        bf_m_out,
    output logic [LOG2N-2:0]        tw_idx,
    input  logic [2*DATA_WIDTH-1:0] tw_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [LOG2N-1:0]        out_index,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int N  = 1 << LOG2N;
    localparam int CW = 2 * DATA_WIDTH;
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    fft_state_t state, state_nxt;

    logic [CW-1:0]         mem [N];
    logic [CW-1:0]         a_dly [A_DELAY];
    logic [BF_LATENCY-1:0] vld_sr;
    logic [LOG2N-1:0]      load_cnt;
    logic [LOG2N-1:0]      out_idx;
    logic [SW-1:0]         s;
    logic [LOG2N-1:0]      addr_a;
    logic [LOG2N-1:0]      addr_b;
    logic [LOG2N-1:0]      load_addr;
    logic [LOG2N-1:0]      wb_addr_b;
    logic                  last_pair;
    logic                  last_stage;
    logic                  load_fire;
    logic                  issue;
    logic                  drain_done;
    logic                  wb_en;
    logic                  unload_fire;

    assign load_fire   = in_valid & in_ready;
    assign unload_fire = out_valid & out_ready;
    assign issue       = (state == S_ISSUE);
    assign wb_en       = vld_sr[BF_LATENCY-1];
    // Empty once the bit retiring on this edge is the only one left.
    assign drain_done  = ((vld_sr << 1) == '0);
    assign load_addr   = LOG2N'(bitrev(32'(load_cnt), LOG2N));
    assign wb_addr_b   = bf_m_out + LOG2N'(32'd1 << s);

    fft_addr_gen #(
        .LOG2N (LOG2N),
        .SW    (SW)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (state == S_LOAD),
        .step_j     (issue),
        .step_s     ((state == S_DRAIN) & drain_done & ~last_stage),
        .s          (s),
        .a          (addr_a),
        .b          (addr_b),
        .tw_idx     (tw_idx),
        .last_pair  (last_pair),
        .last_stage (last_stage)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD:
                if (load_fire && (&load_cnt)) state_nxt = S_ISSUE;
            S_ISSUE:
                if (last_pair) state_nxt = S_DRAIN;
            S_DRAIN:
                if (drain_done)
                    state_nxt = last_stage ? S_UNLOAD : S_ISSUE;
            S_UNLOAD:
                if (unload_fire && (&out_idx)) state_nxt = S_LOAD;
            default:
                state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_LOAD);
        busy      = (state == S_ISSUE) || (state == S_DRAIN);
        out_valid = (state == S_UNLOAD);
    end

    assign out_data  = out_valid ? mem[out_idx] : '0;
    assign out_index = out_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt   <= '0;
            out_idx    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (load_fire)   load_cnt <= load_cnt + 1'b1;
            if (unload_fire) out_idx  <= out_idx + 1'b1;
            frame_done <= unload_fire & (&out_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bf_in_a <= '0;
            bf_in_b <= '0;
            bf_w    <= '0;
            bf_m_in <= '0;
            vld_sr  <= '0;
            for (int i = 0; i < A_DELAY; i++) a_dly[i] <= '0;
        end else begin
            if (issue) begin
                bf_in_b  <= mem[addr_b];
                bf_w     <= tw_data;
                bf_m_in  <= addr_a;
                a_dly[0] <= mem[addr_a];
            end
            // The a-path shifts every cycle so it settles on the last a when idle.
            for (int i = 1; i < A_DELAY; i++) a_dly[i] <= a_dly[i-1];
            bf_in_a <= a_dly[A_DELAY-1];
            vld_sr  <= (vld_sr << 1) | BF_LATENCY'(issue);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
        end else if (wb_en) begin
            mem[bf_m_out]  <= CW'(swap_ri(64'(bf_out_a), DATA_WIDTH));
            mem[wb_addr_b] <= CW'(swap_ri(64'(bf_out_b), DATA_WIDTH));
        end else if (load_fire) begin
            mem[load_addr] <= in_data;
        end
    end

endmodule

// File: doc/fft_r2_stage_ctrl.md
# fft_r2_stage_ctrl

- In-place radix-2 FFT frame controller that drives the `butterfly` datapath.
- Loads N complex samples in bit-reversed order and runs log2(N) stages by issuing one operand pair, twiddle and address tag per cycle. Retires the butterfly results back into its sample store, then streams the finished spectrum out in natural order.
- It sits between the sample source/sink and one `butterfly` instance plus an external twiddle LUT.

## Interface
- DATA_WIDTH, 8, signed bits per re/im component
- LOG2N, 3, log2 of FFT length N (N=8)
- BF_LATENCY, 4, cycles from operand-b issue to result write-back
- A_DELAY, 2, cycles operand a lags operand b/w/tag on the butterfly port
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  high only in LOAD
- in_data  in  2*DATA_WIDTH  sample {im,re}, re in low half
- bf_in_a  out  2*DATA_WIDTH  operand a {im,re}, registered
- bf_in_b  out  2*DATA_WIDTH  operand b {im,re}, registered
- bf_w  out  2*DATA_WIDTH  twiddle {im,re}, registered copy of tw_data
- bf_m_in  out  LOG2N  address of element a, registered
- bf_out_a, bf_out_b  in  2*DATA_WIDTH  results, packed {re,im} (re in high half)
- bf_m_out  in  LOG2N  returned tag, used as write-back address of a
- tw_idx  out  LOG2N-1  combinational twiddle LUT index
- tw_data  in  2*DATA_WIDTH  combinational LUT value W_N^tw_idx, 1.0 = 2^(DATA_WIDTH-2)
- out_valid  out  1  output sample valid
- out_ready  in  1  sink accepts
- out_data  out  2*DATA_WIDTH  spectrum bin {im,re}
- out_index  out  LOG2N  bin number 0..N-1
- busy  out  1  high in ISSUE or DRAIN
- frame_done  out  1  one-cycle pulse after last bin accepted

## Operation
- States are LOAD, ISSUE, DRAIN and UNLOAD. Reset enters LOAD, clears all counters, pipelines and outputs to 0, and sets in_ready=1.
- **LOAD**
  - On in_valid&in_ready, store in_data at bitrev(load_cnt).
  - After the N-th accept, go to ISSUE with stage s=0 and pair j=0.
- **ISSUE**
  - Pair j of stage s: a = ((j>>s)<<(s+1)) | (j & (2^s-1)); b = a + 2^s.
  - tw_idx = (j & (2^s-1)) << (LOG2N-1-s).
  - Each cycle, register mem[b], tw_data and a into bf_in_b, bf_w and bf_m_in.
  - mem[a] enters an A_DELAY-deep delay line feeding bf_in_a.
  - A valid bit enters a BF_LATENCY-deep shift register.
  - After pair N/2-1, go to DRAIN.
- **Write-back (any state)**
  - When the valid shift register outputs 1, write mem[bf_m_out] and mem[bf_m_out + 2^s].
  - The written values are bf_out_a and bf_out_b respectively, halves swapped to {im,re}.
  - Pairs within a stage never alias, so no read/write hazard exists inside a stage.
- **DRAIN**
  - Wait until the valid shift register is empty.
  - If s < LOG2N-1: s++, j=0, go to ISSUE.
  - Otherwise go to UNLOAD with index 0.
- **UNLOAD**
  - out_data = mem[index], out_valid=1.
  - Advance on out_ready.
  - After bin N-1 is accepted: pulse frame_done, go to LOAD.
- **Arithmetic:** the controller performs no arithmetic on data. The per-stage 1/2 scaling belongs to the butterfly, so the output is X[k]/N.
- Idle-cycle bf outputs hold their last value; the valid pipeline gates all writes.

## Timing
- LOAD takes N accepted cycles.
- Each stage takes N/2 issue cycles plus BF_LATENCY drain cycles.
- The first UNLOAD cycle follows the last drain cycle.
- bf_in_b, bf_w and bf_m_in update on the edge ending the issue cycle; bf_in_a follows A_DELAY cycles later.
- in_valid outside LOAD is ignored, because in_ready=0.
- out_ready low stalls UNLOAD indefinitely; out_data and out_index must stay stable while stalled.
- rst_n low mid-frame aborts immediately and discards the frame. The butterfly's in-flight results are not written, because the valid pipeline is cleared.
- In N=8 defaults, a frame with out_ready=1 takes 8 (load) + 3×(4+4) = 24 run cycles + 8 unload cycles.

## Structure
- Shared package `fft_pkg`:
  - state enum
  - bitrev function
  - pair-address and twiddle-index functions
  - packing helpers (swap {re,im} to {im,re})
- Natural sub-module: `fft_addr_gen`, covering the s/j counters, a/b address and tw_idx generation.
- Storage is an N-entry register array with two write ports and two read ports.

## Test plan
- **Impulse:** x[0]=64+0j, others 0, exact twiddle LUT, out_ready=1 -> all 8 bins 8+0j, out_index 0..7, frame_done once.
- **DC:** all samples 32+0j -> bin0=32+0j, bins 1..7 = 0.
- **Address/timing check:**
  - Monitor the bf_m_in sequence in stage 0: 0,2,4,6.
  - Stage 1: 0,1,4,5. Stage 2: 0,1,2,3.
  - tw_idx in stage 2: 0,1,2,3.
  - busy high for exactly 24 cycles.
- **Backpressure:** toggle out_ready 1-0-0-1 during UNLOAD -> no bin lost or duplicated, data stable while stalled.
- **Reset mid-ISSUE:** assert rst_n low during stage 1 -> all outputs 0, in_ready=1 after release; the next impulse frame gives correct results.
- **Back-to-back frames:** impulse then DC with no gap -> second frame loads immediately after frame_done with correct results.
